// File: rtl/risc_v_mem_pkg.sv
// Shared memory-side definitions so the data cache and the main-memory controller
// agree on word width, line size and access latency.
package risc_v_mem_pkg;

    localparam int WORD_W             = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_LATENCY        = 4;
    localparam int DEF_DEPTH_WORDS    = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } mem_state_e;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are deliberately not reset; they survive controller resets.
module mem_word_array
    import risc_v_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_mem_ctrl.sv
// Line-granular main-memory controller: one refill or write-back at a time,
// a latency countdown, then one word per cycle through the word array.
module main_mem_ctrl
    import risc_v_mem_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int DEPTH_WORDS    = DEF_DEPTH_WORDS,
    parameter int LATENCY        = DEF_LATENCY
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_write,
    input  logic [31:0]                             req_addr,
    input  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   req_wdata,
    output logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   rsp_rdata,
    output logic                                    done,
    output logic                                    busy
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int BW    = $clog2(WORDS_PER_LINE);
    localparam int LW    = AW - BW;
    localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    mem_state_e        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              write_q, write_d;
    logic [LW-1:0]     line_q, line_d;
    line_t             wbuf_q, wbuf_d;
    line_t             rbuf_q, rbuf_d;
    line_t             rsp_q, rsp_d;

    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    // Line base is aligned, so base+beat mod depth is just {line, beat}.
    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .addr_i  ({line_q, beat_q}),
        .wdata_i (wbuf_q[beat_q]),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            write_q <= 1'b0;
            line_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            write_q <= write_d;
            line_q  <= line_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        write_d = write_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        rbuf_d  = rbuf_q;
        rsp_d   = rsp_q;
        arr_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    line_d  = req_addr[AW+1:BW+2];
                    wbuf_d  = req_wdata;
                    beat_d  = '0;
                    if (LATENCY == 0) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) state_d = ST_XFER;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            ST_XFER: begin
                // Writes mirror their data into the buffer so the response is uniform.
                arr_we         = write_q;
                rbuf_d[beat_q] = write_q ? wbuf_q[beat_q] : arr_rdata;
                beat_d         = beat_q + BW'(1);
                if (beat_q == BW'(WORDS_PER_LINE - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                rsp_d   = rbuf_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    // The buffer fills beat by beat; outside DONE show the last completed line.
    assign rsp_rdata = done ? rbuf_q : rsp_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: default build plus a LATENCY=0 build, checked against
// a word-level memory model and cycle counts derived from the timing rules.
module tb_main_mem_ctrl;

    localparam int W     = 4;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid0 = 1'b0, valid1 = 1'b0;
    logic         wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [127:0] rdata0, rdata1;
    logic         ready0, ready1, done0, done1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    main_mem_ctrl #(.WORDS_PER_LINE(W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u0 (
        .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0),
        .req_write(wr), .req_addr(addr), .req_wdata(wdata), .rsp_rdata(rdata0),
        .done(done0), .busy(busy0));

    main_mem_ctrl #(.WORDS_PER_LINE(W), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
        .req_write(wr), .req_addr(addr), .req_wdata(wdata), .rsp_rdata(rdata1),
        .done(done1), .busy(busy1));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a, input int b);
        return int'((((a >> 2) & 32'hffff_fffc) + 32'(b)) % DEPTH);
    endfunction

    function automatic logic [127:0] model_line(input logic [31:0] a);
        logic [127:0] l;
        for (int b = 0; b < W; b++) l[32*b +: 32] = mdl[widx(a, b)];
        return l;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [127:0] d);
        for (int b = 0; b < W; b++) mdl[widx(a, b)] = d[32*b +: 32];
    endtask

    // One full transaction; lat is the number of edges from acceptance to done.
    task automatic do_req(input bit sel, input bit w, input logic [31:0] a,
                          input logic [127:0] d, output logic [127:0] r, output int lat);
        @(negedge clk);
        chk("ready_before_req", sel ? ready1 : ready0, 1'b1);
        wr = w; addr = a; wdata = d;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0; valid1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(sel ? done1 : done0) && lat < 40);
        r = sel ? rdata1 : rdata0;
        if (lat >= 40) chk("done_timeout", 0, 1);
        chk("busy_at_done", sel ? busy1 : busy0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] r, d;
        logic [31:0]  a;
        int lat;
        int acc [$];
        int dn  [$];
        bit sawdone;

        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("rst_ready", ready0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_rdata", rdata0, '0);

        // Write then read line 0x40
        d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        do_req(0, 1, 32'h40, d, r, lat); model_write(32'h40, d);
        chk("wr40_lat", lat, 8);
        chk("wr40_mirror", r, d);
        do_req(0, 0, 32'h40, '0, r, lat);
        chk("rd40_lat", lat, 8);
        chk("rd40_data", r, d);
        do_req(0, 0, 32'h4C, '0, r, lat);
        chk("rd4C_align", r, d);
        d = {32'hdddd0004, 32'hcccc0003, 32'hbbbb0002, 32'haaaa0001};
        do_req(0, 1, 32'h1040, d, r, lat); model_write(32'h1040, d);
        do_req(0, 0, 32'h40, '0, r, lat);
        chk("alias_1040", r, d);
        chk("alias_model", r, model_line(32'h40));

        // LATENCY=0 build
        d = {32'h0badf00d, 32'hcafe0002, 32'h12345678, 32'h9abcdef0};
        do_req(1, 1, 32'h80, d, r, lat);
        chk("l0_wr_lat", lat, 4);
        do_req(1, 0, 32'h84, '0, r, lat);
        chk("l0_rd_lat", lat, 4);
        chk("l0_rd_data", r, d);

        // Randomized traffic over 16 lines with random alias/offset bits
        for (int k = 0; k < 16; k++) begin
            a = {$urandom_range(0, 32'hfffff), 12'(k * 16 + $urandom_range(0, 15))};
            d = {$urandom, $urandom, $urandom, $urandom};
            do_req(0, 1, a, d, r, lat); model_write(a, d);
            chk("rnd_wr_mirror", r, d);
        end
        for (int k = 0; k < 30; k++) begin
            a = {$urandom_range(0, 32'hfffff), 12'($urandom_range(0, 15) * 16 + $urandom_range(0, 15))};
            d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                do_req(0, 1, a, d, r, lat); model_write(a, d);
                chk("rnd_wr_mirror", r, d);
            end else begin
                do_req(0, 0, a, '0, r, lat);
                chk("rnd_rd_data", r, model_line(a));
            end
            chk("rnd_lat", lat, 8);
        end

        // Busy handshake: request held high continuously
        @(negedge clk);
        wr = 1'b0; addr = 32'h30; valid0 = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (acc.size() == 2) valid0 = 1'b0;
            if (valid0 && ready0) acc.push_back(c);
            @(posedge clk); #1;
            if (done0) begin
                dn.push_back(c);
                chk("hs_data", rdata0, model_line(32'h30));
            end
            @(negedge clk);
        end
        valid0 = 1'b0;
        chk("hs_nacc", acc.size(), 2);
        chk("hs_ndone", dn.size(), 2);
        if (acc.size() == 2 && dn.size() == 2) begin
            chk("hs_period", acc[1] - acc[0], 10);
            chk("hs_done_lat", dn[0] - acc[0], 8);
            chk("hs_done_before_2nd", dn[0] < acc[1], 1'b1);
        end

        // Asynchronous reset mid-cycle while busy; rsp_rdata was nonzero
        @(negedge clk);
        addr = 32'h50; wr = 1'b0; valid0 = 1'b1;
        @(posedge clk); #1; valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_ready", ready0, 1'b1);
        chk("arst_busy", busy0, 1'b0);
        chk("arst_done", done0, 1'b0);
        chk("arst_rdata", rdata0, '0);
        @(negedge clk); reset = 1'b0;

        // Reset after beat 1 of a write over zeros
        do_req(0, 1, 32'h100, '0, r, lat); model_write(32'h100, '0);
        @(negedge clk);
        wr = 1'b1; addr = 32'h100;
        wdata = {32'hdddddddd, 32'hcccccccc, 32'hbbbbbbbb, 32'haaaaaaaa};
        valid0 = 1'b1;
        @(posedge clk); #1; valid0 = 1'b0;
        sawdone = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) begin
            @(posedge clk); #1;
            if (done0) sawdone = 1'b1;
        end
        #1 reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done0) sawdone = 1'b1;
        end
        @(negedge clk); reset = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done0) sawdone = 1'b1;
        end
        chk("xrst_no_done", sawdone, 1'b0);
        mdl[widx(32'h100, 0)] = 32'haaaaaaaa;
        mdl[widx(32'h100, 1)] = 32'hbbbbbbbb;
        do_req(0, 0, 32'h100, '0, r, lat);
        chk("xrst_partial", r, {32'h0, 32'h0, 32'hbbbbbbbb, 32'haaaaaaaa});
        chk("xrst_model", r, model_line(32'h100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Line-granular main-memory controller behind the data cache: accepts one cache-line refill (read) or write-back (write) request at a time, models DRAM access latency with a countdown, then moves the line one 32-bit word per cycle through a single-ported word array. It returns the whole line with a one-cycle `done` pulse. The cache drives core `stall` from `busy`/`done`.

## Interface
Parameters:
- `WORDS_PER_LINE`, 4: words per cache line; power of two, ≥2.
- `DEPTH_WORDS`, 1024: storage size in 32-bit words; power of two, multiple of `WORDS_PER_LINE`.
- `LATENCY`, 4: access wait cycles before the first word moves; 0 is legal.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept; high only in IDLE.
- `req_write`  in  1: 1 = write-back, 0 = refill.
- `req_addr`  in  32: byte address. Low `log2(WORDS_PER_LINE)+2` bits ignored (line-aligned).
- `req_wdata`  in  32×`WORDS_PER_LINE`: line data. Word i is at bits [32i+31:32i].
- `rsp_rdata`  out  32×`WORDS_PER_LINE`: line contents after the operation; valid while `done`=1.
- `done`  out  1: one-cycle completion pulse.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, XFER, DONE.
- **IDLE:** `req_ready`=1. When `req_valid`=1 at a clock edge, the request is accepted:
  - Capture `req_write`, line base, and `req_wdata`.
  - Go to WAIT with the latency counter = `LATENCY`-1. If `LATENCY`=0, go directly to XFER.
- **WAIT:** decrement the counter each cycle. At 0, go to XFER with beat = 0.
- **XFER:** one array access per cycle, at word index (line_base_word + beat) mod `DEPTH_WORDS`.
  - Write: store captured word[beat] into the array.
  - Read: load the array word into rdata buffer[beat].
  - After beat = `WORDS_PER_LINE`-1, go to DONE.
- **DONE:** `done`=1 for exactly one cycle. `rsp_rdata` = rdata buffer. For writes, the buffer mirrors the written data, so `rsp_rdata` equals `req_wdata`. Go to IDLE.
- `req_valid` outside IDLE is ignored. No queueing; the requester holds its request until `req_ready`.
- Address bits above `log2(DEPTH_WORDS)+2` are ignored, so addresses alias/wrap modulo storage.
- Reset mid-operation:
  - State → IDLE, counters cleared, request dropped with no `done`.
  - Words already written stay written; remaining words are not written.
- Array contents are not affected by reset and are undefined at power-up.

## Timing
- Reset values: `req_ready`=1, `done`=0, `busy`=0, `rsp_rdata`=0. State IDLE, counters 0.
- Request accepted at edge E0. Then:
  - `busy` is high from E0 to E0+`LATENCY`+`WORDS_PER_LINE`+1.
  - `done` is high between edges E0+`LATENCY`+`WORDS_PER_LINE` and the next edge.
  - Defaults (4, 4): `done` is visible 8 cycles after acceptance.
- `req_ready` returns high in the cycle after `done`. Back-to-back period = `LATENCY`+`WORDS_PER_LINE`+2 cycles.
- Array write is synchronous. Array read is combinational, registered into the buffer at the XFER edge.
- A read issued after a write completes sees the new data, with no hazard window.
- `rsp_rdata` holds its last value until the next DONE.

## Structure
- Shared package `risc_v_mem_pkg`:
  - FSM state encoding.
  - `WORD_W`=32.
  - Default `WORDS_PER_LINE` and `LATENCY` constants, so the cache and controller agree on line size.
- Counter widths derived by clog2 in the module: latency counter clog2(`LATENCY`+1), beat counter log2(`WORDS_PER_LINE`).
- Sub-module `mem_word_array`: single-port `DEPTH_WORDS`×32 array with synchronous write enable and asynchronous read. The controller holds FSM, capture, and buffer registers.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → `req_ready`=1, `busy`=0, `done`=0, `rsp_rdata`=0 immediately.
- **Write then read:** write line at 0x0000_0040 with words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → `done` 8 cycles after acceptance. Then read 0x0000_0040 → `rsp_rdata` returns the same four words in order.
- **Alignment:** read at 0x0000_004C → same line as 0x0000_0040. Write with addr 0x0000_1040 (`DEPTH_WORDS`=1024) → aliases and overwrites line 0x0000_0040.
- **Busy handshake:** pulse `req_valid` while busy → ignored, exactly one `done`. Issue the next request the cycle `req_ready` rises → accepted, period = 10 cycles.
- **LATENCY=0 build:** read completes with `done` 4 cycles after acceptance.
- **Reset during XFER:** assert reset after beat 1 of a write of A,B,C,D over old 0s → no `done`. A later read returns A,B,0,0.
